// File: rtl/seq_gen_fsm.sv
// seq_gen_fsm: serial pattern burst generator, PATTERN sent MSB first rep_cnt times, optional idle gap between repetitions.
module seq_gen_fsm #(
    parameter int                   PAT_WIDTH  = 5,
    parameter logic [PAT_WIDTH-1:0] PATTERN    = 5'b10110,
    parameter int                   GAP_CYCLES = 0,
    parameter int                   REP_WIDTH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [REP_WIDTH-1:0] repeat_i,
    input  logic                 abort_i,
    output logic                 data_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int IW    = PAT_WIDTH > 1 ? $clog2(PAT_WIDTH) : 1;
    localparam int GLAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
    localparam int GW    = GLAST > 0 ? $clog2(GLAST + 1) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(PAT_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GLAST);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
    state_t               state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [REP_WIDTH:0]   rep_cnt, rep_n;
    logic [GW-1:0]        gap_cnt, gap_n;
    logic                 done_n;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            idx     <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            done_o  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            rep_cnt <= rep_n;
            gap_cnt <= gap_n;
            done_o  <= done_n;
        end
    end
    // Every path not explicitly continuing the burst falls back to IDLE with counters cleared.
    always_comb begin
        state_n = IDLE;
        idx_n   = '0;
        rep_n   = '0;
        gap_n   = '0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_n = SEND;
                    rep_n   = {1'b0, repeat_i} + {{REP_WIDTH{1'b0}}, 1'b1};
                end
            end
            SEND: begin
                if (!abort_i) begin
                    if (idx != IDX_LAST) begin
                        state_n = SEND;
                        idx_n   = idx + 1'b1;
                        rep_n   = rep_cnt;
                    end else if (rep_cnt > 1) begin
                        state_n = GAP_CYCLES == 0 ? SEND : GAP;
                        rep_n   = rep_cnt - 1'b1;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!abort_i) begin
                    rep_n   = rep_cnt;
                    state_n = gap_cnt == GAP_LAST ? SEND : GAP;
                    gap_n   = gap_cnt == GAP_LAST ? '0 : gap_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    assign valid_o = state == SEND;
    assign data_o  = valid_o & PATTERN[IDX_LAST - idx];
    assign last_o  = valid_o & (idx == IDX_LAST);
    assign busy_o  = state == SEND || state == GAP;
endmodule

// File: doc/seq_gen_fsm.md
SEQ_GEN_FSM -- requirements
Module: seq_gen_fsm

Interface
REQ-001 Parameter PAT_WIDTH, default 5, pattern length in bits; legal range >= 1.
REQ-002 Parameter PATTERN [PAT_WIDTH-1:0], default 5'b10110, transmitted MSB first.
REQ-003 Parameter GAP_CYCLES, default 0, idle cycles between consecutive repetitions; legal range >= 0.
REQ-004 Parameter REP_WIDTH, default 4, width of the repeat-count input.
REQ-005 The block SHALL have one clock, clk_i, and an asynchronous, active-high reset, rst_i.
REQ-006 Port list:
 - clk_i     input   1          clock, rising edge
 - rst_i     input   1          async active-high reset
 - start_i   input   1          request a burst; sampled only when busy_o=0
 - repeat_i  input   REP_WIDTH  burst repetitions minus one, captured with start_i
 - abort_i   input   1          synchronous burst cancel
 - data_o    output  1          serial pattern bit
 - valid_o   output  1          data_o carries a pattern bit this cycle
 - last_o    output  1          data_o is the final bit (PATTERN[0]) of a repetition
 - busy_o    output  1          burst in progress (state != IDLE)
 - done_o    output  1          one-cycle pulse, burst completed normally

Function
REQ-007 All outputs SHALL be registered or decoded directly from state registers, with no combinational path from any input to any output.
REQ-008 The FSM SHALL have the states IDLE, SEND and GAP.
REQ-009 IDLE SHALL drive data_o=0, valid_o=0, last_o=0 and busy_o=0.
REQ-010 When start_i=1 and abort_i=0 at an edge in IDLE, the block SHALL capture rep_cnt = repeat_i + 1 (range 1..2^REP_WIDTH, computed at REP_WIDTH+1 bits) and enter SEND with bit index 0.
REQ-011 In SEND, valid_o SHALL be 1 and data_o SHALL equal PATTERN[PAT_WIDTH-1-idx]; idx advances by one per cycle from 0 to PAT_WIDTH-1.
REQ-012 The first pattern bit SHALL appear on data_o in the cycle after the start edge (latency 1 cycle).
REQ-013 last_o SHALL be 1 exactly when in SEND with idx = PAT_WIDTH-1.
REQ-014 After the last bit of a repetition, the block SHALL decrement rep_cnt and act as follows:
 - rep_cnt was > 1 and GAP_CYCLES=0: stay in SEND with idx=0, giving back-to-back repetitions with no bubble.
 - rep_cnt was > 1 and GAP_CYCLES>0: enter GAP.
 - rep_cnt was 1: return to IDLE and assert done_o for exactly one cycle.
REQ-015 GAP SHALL last exactly GAP_CYCLES cycles with valid_o=0, data_o=0 and busy_o=1, then enter SEND with idx=0.
REQ-016 start_i SHALL be ignored while busy_o=1.
REQ-017 A start_i in the done_o cycle (busy_o=0) SHALL be accepted, with its first bit in the following cycle.
REQ-018 abort_i=1 at an edge in SEND or GAP SHALL return the block to IDLE in the next cycle, with no done_o pulse and rep_cnt/idx cleared.
REQ-019 abort_i in IDLE SHALL have no effect; abort_i and start_i together in IDLE SHALL leave the block in IDLE.
REQ-020 With PAT_WIDTH=1, every SEND cycle SHALL also assert last_o.
REQ-021 An unreachable state encoding SHALL return the block to IDLE on the next edge.

Reset
REQ-022 While rst_i=1, independent of clk_i, the block SHALL force state=IDLE, idx=0 and rep_cnt=0, and drive data_o, valid_o, last_o, busy_o and done_o to 0.
REQ-023 Reset asserted mid-burst SHALL discard the burst; after deassertion the block SHALL wait in IDLE for a new start_i.

Verification
REQ-024 Defaults, start_i=1 with repeat_i=0 for one cycle: data_o=1,0,1,1,0 with valid_o=1 in cycles 1-5, last_o=1 in cycle 5, done_o=1 and busy_o=0 in cycle 6.
REQ-025 Defaults, repeat_i=2: 15 contiguous valid bits (10110 x3), last_o in cycles 5, 10 and 15, done_o in cycle 16.
REQ-026 GAP_CYCLES=2, repeat_i=1: bits in cycles 1-5, valid_o=0 and busy_o=1 in cycles 6-7, bits in cycles 8-12, done_o in cycle 13.
REQ-027 abort_i=1 at the 3rd bit of a burst: valid_o=0 and busy_o=0 from the next cycle, done_o never asserted; start_i pulses during the burst are ignored.
REQ-028 rst_i asserted asynchronously between clock edges mid-burst: all outputs are 0 immediately; a start_i after release produces a full fresh pattern.
REQ-029 Loopback: data_o, qualified by valid_o, fed to an overlapping 10110 detector yields one detection per repetition, each one cycle after last_o; a start_i in the done_o cycle yields back-to-back bursts.
